// File: rtl/fst_arb_pkg.sv
// Shared types and constants for the memory/lock arbiter.
package fst_arb_pkg;

    localparam int unsigned NLOCK   = 16;
    localparam int unsigned LOCK_AW = 4;
    // Owner field sized for the largest supported core count (16).
    localparam int unsigned MAX_C   = 16;
    localparam int unsigned CORE_W  = $clog2(MAX_C);

    typedef logic [CORE_W-1:0] core_id_t;

    typedef struct packed {
        logic     valid;
        core_id_t owner;
    } lock_entry_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOCK,
        OP_UNLOCK
    } lock_op_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] cand;
        cand = '0;
        gnt  = '0;
        any  = 1'b0;
        idx  = '0;
        // N is a power of two, so IW-bit addition wraps modulo N.
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr + IW'(k);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Core-to-main_mem arbiter and 16-entry lock table with one-cycle grants/acks.
// Optional MEM_ARB_WAIT_CNT_EN adds a saturating pending-request cycle counter.
module mem_lock_arbiter
    import fst_arb_pkg::*;
#(
    parameter int unsigned C     = 8,
    parameter int unsigned NLOCK = fst_arb_pkg::NLOCK
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [C-1:0]         main_mem_read_request,
    input  logic [C-1:0]         main_mem_write_request,
    input  logic [C-1:0]         main_mem_read,
    input  logic [C-1:0]         main_mem_write,
    input  logic [C*16-1:0]      main_mem_read_adr,
    input  logic [C*16-1:0]      main_mem_write_adr,
    input  logic [C*16-1:0]      main_mem_write_dat,
    output logic [C-1:0]         main_mem_ac,
    output logic [15:0]          mem_read_adr,
    output logic [15:0]          mem_write_adr,
    output logic [15:0]          mem_write_dat,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [C*LOCK_AW-1:0] lock_adr,
    input  logic [C-1:0]         lock_en,
    input  logic [C-1:0]         unlock_en,
`ifdef MEM_ARB_WAIT_CNT_EN
    output logic [31:0]          wait_cnt,
`endif
    output logic [C-1:0]         lock_ac
);

    localparam int unsigned IW = $clog2(C);

    logic [C-1:0]  mem_req, mem_elig, mem_gnt, ac_q;
    logic          mem_any;
    logic [IW-1:0] mem_idx, mem_ptr;

    // A core granted last cycle is masked so it never gets two grants in a row.
    assign mem_req  = main_mem_read_request | main_mem_write_request;
    assign mem_elig = mem_req & ~ac_q;

    rr_pick #(.N(C)) u_mem_pick (
        .req (mem_elig),
        .ptr (mem_ptr),
        .gnt (mem_gnt),
        .any (mem_any),
        .idx (mem_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac_q    <= '0;
            mem_ptr <= '0;
        end else begin
            ac_q <= mem_gnt;
            if (mem_any) mem_ptr <= mem_idx + IW'(1);
        end
    end

    assign main_mem_ac = ac_q;

    always_comb begin
        mem_read_adr  = '0;
        mem_write_adr = '0;
        mem_write_dat = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        for (int unsigned i = 0; i < C; i++) begin
            if (ac_q[i]) begin
                mem_read_adr  = main_mem_read_adr[i*16 +: 16];
                mem_write_adr = main_mem_write_adr[i*16 +: 16];
                mem_write_dat = main_mem_write_dat[i*16 +: 16];
                mem_read      = main_mem_read[i];
                mem_write     = main_mem_write[i];
            end
        end
    end

    lock_entry_t          lock_tab [NLOCK];
    logic [C-1:0]         lock_elig, lock_gnt, lac_q;
    logic                 lock_any;
    logic [IW-1:0]        lock_idx, lock_ptr;
    logic [LOCK_AW-1:0]   op_adr;
    lock_op_e             op;

    always_comb begin
        lock_entry_t        ent;
        logic [LOCK_AW-1:0] adr;
        ent       = '0;
        adr       = '0;
        lock_elig = '0;
        for (int unsigned i = 0; i < C; i++) begin
            adr = lock_adr[i*LOCK_AW +: LOCK_AW];
            ent = lock_tab[adr];
            lock_elig[i] = (lock_en[i] | unlock_en[i]) & ~lac_q[i] &
                           (unlock_en[i] | ~ent.valid | (ent.owner == CORE_W'(i)));
        end
    end

    rr_pick #(.N(C)) u_lock_pick (
        .req (lock_elig),
        .ptr (lock_ptr),
        .gnt (lock_gnt),
        .any (lock_any),
        .idx (lock_idx)
    );

    // Unlock takes priority when a core raises both enables.
    always_comb begin
        op     = OP_NONE;
        op_adr = lock_adr[32'(lock_idx)*LOCK_AW +: LOCK_AW];
        if (lock_any) op = unlock_en[lock_idx] ? OP_UNLOCK : OP_LOCK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lac_q    <= '0;
            lock_ptr <= '0;
            for (int unsigned e = 0; e < NLOCK; e++) lock_tab[e] <= '0;
        end else begin
            lac_q <= lock_gnt;
            if (lock_any) lock_ptr <= lock_idx + IW'(1);
            case (op)
                OP_LOCK: begin
                    if (!lock_tab[op_adr].valid) begin
                        lock_tab[op_adr].valid <= 1'b1;
                        lock_tab[op_adr].owner <= CORE_W'(lock_idx);
                    end
                end
                OP_UNLOCK: begin
                    if (lock_tab[op_adr].valid &&
                        lock_tab[op_adr].owner == CORE_W'(lock_idx))
                        lock_tab[op_adr].valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign lock_ac = lac_q;

`ifdef MEM_ARB_WAIT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (|(mem_req & ~ac_q) && wait_cnt != '1)
            wait_cnt <= wait_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Self-checking bench for mem_lock_arbiter against a behavioural reference model.
module tb_mem_lock_arbiter;

    localparam int C  = 8;
    localparam int NL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [C-1:0]    rreq, wreq, rd, wr, lock_en, unlock_en;
    logic [C*16-1:0] radr, wadr, wdat;
    logic [C*4-1:0]  ladr;
    logic [C-1:0]    ac, lac;
    logic [15:0]     m_radr, m_wadr, m_wdat;
    logic            m_rd, m_wr;

    mem_lock_arbiter #(.C(C), .NLOCK(NL)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .main_mem_read_request  (rreq),
        .main_mem_write_request (wreq),
        .main_mem_read          (rd),
        .main_mem_write         (wr),
        .main_mem_read_adr      (radr),
        .main_mem_write_adr     (wadr),
        .main_mem_write_dat     (wdat),
        .main_mem_ac            (ac),
        .mem_read_adr           (m_radr),
        .mem_write_adr          (m_wadr),
        .mem_write_dat          (m_wdat),
        .mem_read               (m_rd),
        .mem_write              (m_wr),
        .lock_adr               (ladr),
        .lock_en                (lock_en),
        .unlock_en              (unlock_en),
        .lock_ac                (lac)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int       m_ptr, l_ptr;
    bit [C-1:0] m_last, l_last;
    bit       lv [NL];
    int       lo [NL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit [C-1:0] e, input int ptr);
        for (int k = 0; k < C; k++)
            if (e[(ptr + k) % C]) return (ptr + k) % C;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; l_ptr = 0; m_last = '0; l_last = '0;
        for (int e = 0; e < NL; e++) begin lv[e] = 0; lo[e] = 0; end
    endtask

    task automatic clear_inputs();
        rreq = '0; wreq = '0; rd = '0; wr = '0;
        radr = '0; wadr = '0; wdat = '0;
        ladr = '0; lock_en = '0; unlock_en = '0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic tick();
        bit [C-1:0]  me, le;
        logic [C-1:0] exp_ac, exp_lac;
        int mw, lw, a;
        logic [15:0] e_radr, e_wadr, e_wdat;
        logic e_rd, e_wr;
        for (int i = 0; i < C; i++) begin
            me[i] = (rreq[i] | wreq[i]) && !m_last[i];
            a = int'(ladr[i*4 +: 4]);
            le[i] = (lock_en[i] | unlock_en[i]) && !l_last[i] &&
                    (unlock_en[i] || !lv[a] || lo[a] == i);
        end
        mw = pick(me, m_ptr);
        lw = pick(le, l_ptr);
        exp_ac = '0; exp_lac = '0;
        e_radr = '0; e_wadr = '0; e_wdat = '0; e_rd = 0; e_wr = 0;
        if (mw >= 0) begin
            exp_ac[mw] = 1'b1;
            m_ptr = (mw + 1) % C;
            e_radr = radr[mw*16 +: 16];
            e_wadr = wadr[mw*16 +: 16];
            e_wdat = wdat[mw*16 +: 16];
            e_rd = rd[mw];
            e_wr = wr[mw];
        end
        if (lw >= 0) begin
            exp_lac[lw] = 1'b1;
            l_ptr = (lw + 1) % C;
            a = int'(ladr[lw*4 +: 4]);
            if (unlock_en[lw]) begin
                if (lv[a] && lo[a] == lw) lv[a] = 0;
            end else if (!lv[a]) begin
                lv[a] = 1; lo[a] = lw;
            end
        end
        m_last = exp_ac;
        l_last = exp_lac;
        @(posedge clk);
        #1;
        check("main_mem_ac", 32'(ac), 32'(exp_ac));
        check("lock_ac", 32'(lac), 32'(exp_lac));
        check("mem_read", 32'(m_rd), 32'(e_rd));
        check("mem_write", 32'(m_wr), 32'(e_wr));
        check("mem_read_adr", 32'(m_radr), 32'(e_radr));
        check("mem_write_adr", 32'(m_wadr), 32'(e_wadr));
        check("mem_write_dat", 32'(m_wdat), 32'(e_wdat));
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 1'b0;
        #12;
        check("rst_ac", 32'(ac), 32'h0);
        check("rst_lac", 32'(lac), 32'h0);
        check("rst_mem_rw", 32'({m_rd, m_wr}), 32'h0);
        reset_n = 1'b1;

        // All cores request continuously: grants walk 0..7 then wrap to 0.
        rreq = '1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_walk", 32'(ac), 32'(8'h01 << (k % C)));
        end
        rreq = '0;
        tick();

        // Single write from core 3.
        wreq[3] = 1'b1; wr[3] = 1'b1;
        wadr[3*16 +: 16] = 16'h0010; wdat[3*16 +: 16] = 16'hBEEF;
        tick();
        check("c3_ac", 32'(ac), 32'h08);
        check("c3_wr", 32'(m_wr), 32'h1);
        check("c3_adr", 32'(m_wadr), 32'h0010);
        check("c3_dat", 32'(m_wdat), 32'hBEEF);
        clear_inputs();
        tick();
        check("c3_idle", 32'(ac), 32'h0);

        // Core 5 held for four cycles: grant, gap, grant, gap.
        rreq[5] = 1'b1; rd[5] = 1'b1; radr[5*16 +: 16] = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("c5_pattern", 32'(ac), (k % 2 == 0) ? 32'h20 : 32'h0);
            check("c5_rd", 32'(m_rd), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        clear_inputs();
        tick();

        // Lock handover on index 4: core 1 owns, core 2 waits, unlock releases.
        ladr[1*4 +: 4] = 4'd4; lock_en[1] = 1'b1;
        tick();
        check("l1_lock", 32'(lac), 32'h02);
        lock_en[1] = 1'b0;
        ladr[2*4 +: 4] = 4'd4; lock_en[2] = 1'b1;
        tick();
        check("l2_pend_a", 32'(lac), 32'h0);
        tick();
        check("l2_pend_b", 32'(lac), 32'h0);
        unlock_en[1] = 1'b1;
        tick();
        check("l1_unlock", 32'(lac), 32'h02);
        unlock_en[1] = 1'b0;
        tick();
        check("l2_lock", 32'(lac), 32'h04);
        lock_en[2] = 1'b0;
        tick();

        // Core 6: unlock of a free entry, then two locks of the same entry.
        ladr[6*4 +: 4] = 4'd9; unlock_en[6] = 1'b1;
        tick();
        check("l6_unlock_free", 32'(lac), 32'h40);
        unlock_en[6] = 1'b0;
        tick();
        lock_en[6] = 1'b1;
        tick();
        check("l6_lock_a", 32'(lac), 32'h40);
        lock_en[6] = 1'b0;
        tick();
        lock_en[6] = 1'b1;
        tick();
        check("l6_lock_b", 32'(lac), 32'h40);
        lock_en[6] = 1'b0;
        ladr[0*4 +: 4] = 4'd9; lock_en[0] = 1'b1;
        tick();
        check("l0_blocked", 32'(lac), 32'h0);
        lock_en[0] = 1'b0;
        tick();

        // Reset while grants are active and locks 4/9 are held.
        rreq = '1; rd = '1;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ac", 32'(ac), 32'h0);
        check("mid_rst_lac", 32'(lac), 32'h0);
        check("mid_rst_rd", 32'(m_rd), 32'h0);
        check("mid_rst_radr", 32'(m_radr), 32'h0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        ladr[0*4 +: 4] = 4'd9; lock_en[0] = 1'b1;
        ladr[3*4 +: 4] = 4'd4; lock_en[3] = 1'b1;
        tick();
        check("post_rst_l0", 32'(lac), 32'h01);
        lock_en[0] = 1'b0;
        tick();
        check("post_rst_l3", 32'(lac), 32'h08);
        clear_inputs();
        tick();

        // Randomized traffic with lock contention on a few indices.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < C; i++) begin
                rreq[i] = ($urandom_range(0, 99) < 35);
                wreq[i] = ($urandom_range(0, 99) < 25);
                rd[i]   = $urandom_range(0, 1);
                wr[i]   = $urandom_range(0, 1);
                radr[i*16 +: 16] = 16'($urandom);
                wadr[i*16 +: 16] = 16'($urandom);
                wdat[i*16 +: 16] = 16'($urandom);
                ladr[i*4 +: 4]   = 4'($urandom_range(0, 3));
                lock_en[i]   = ($urandom_range(0, 99) < 30);
                unlock_en[i] = ($urandom_range(0, 99) < 15);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
